// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: memory/writeback pipeline entry, commit-order
// width and the zero bubble used for flushes and reset.
package rv32i_types;

    localparam int unsigned ORDER_W = 64;

    typedef struct packed {
        logic               commit;
        logic [ORDER_W-1:0] order;
        logic [31:0]        inst;
        logic [31:0]        pc;
        logic [31:0]        pc_next;
        logic [4:0]         rs1_s;
        logic [4:0]         rs2_s;
        logic [31:0]        rs1_v;
        logic [31:0]        rs2_v;
        logic               regf_we;
        logic [4:0]         rd_s;
        logic [31:0]        rd_v;
    } mem_wb_reg_t;

    localparam mem_wb_reg_t WB_BUBBLE = '0;

endpackage

// File: rtl/wb_stage_if.sv
// Writeback stage bus: entry and pipeline controls from the memory stage,
// commit order back to it, register-file write, forwarding and retirement
// monitor outputs.
interface wb_stage_if import rv32i_types::*; ();

    mem_wb_reg_t        mem_wb_reg;
    logic               stall;
    logic               flush;
    logic               increment;
    logic [ORDER_W-1:0] order;

    logic               regf_we;
    logic [4:0]         rd_s;
    logic [31:0]        rd_v;

    logic               fwd_valid;
    logic [4:0]         fwd_rd_s;
    logic [31:0]        fwd_rd_v;

    logic               mon_valid;
    logic [ORDER_W-1:0] mon_order;
    logic [31:0]        mon_inst;
    logic [31:0]        mon_pc_rdata;
    logic [31:0]        mon_pc_wdata;
    logic [4:0]         mon_rs1_addr;
    logic [4:0]         mon_rs2_addr;
    logic [31:0]        mon_rs1_rdata;
    logic [31:0]        mon_rs2_rdata;
    logic [4:0]         mon_rd_addr;
    logic [31:0]        mon_rd_wdata;

    modport master (
        output mem_wb_reg, stall, flush, increment,
        input  order, regf_we, rd_s, rd_v, fwd_valid, fwd_rd_s, fwd_rd_v,
        input  mon_valid, mon_order, mon_inst, mon_pc_rdata, mon_pc_wdata,
        input  mon_rs1_addr, mon_rs2_addr, mon_rs1_rdata, mon_rs2_rdata,
        input  mon_rd_addr, mon_rd_wdata
    );

    modport slave (
        input  mem_wb_reg, stall, flush, increment,
        output order, regf_we, rd_s, rd_v, fwd_valid, fwd_rd_s, fwd_rd_v,
        output mon_valid, mon_order, mon_inst, mon_pc_rdata, mon_pc_wdata,
        output mon_rs1_addr, mon_rs2_addr, mon_rs1_rdata, mon_rs2_rdata,
        output mon_rd_addr, mon_rd_wdata
    );

endinterface

// File: rtl/wb_stage_order_counter.sv
// Commit order counter: free-running 64-bit count of committed instructions,
// wrapping naturally at 2^64.
module order_counter import rv32i_types::*; (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic [ORDER_W-1:0] order
);

    logic [ORDER_W-1:0] order_q;

    // Advance by one per enabled edge; synchronous clear on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            order_q <= '0;
        end else if (en) begin
            order_q <= order_q + ORDER_W'(1);
        end
    end

    assign order = order_q;

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: registers the memory-stage entry, drives the register-file
// write port and forwarding path, and reports each committed instruction
// exactly once on the retirement monitor.
module wb_stage import rv32i_types::*; (
    input  logic       clk,
    input  logic       rst,
    wb_stage_if.slave  wb
);

    mem_wb_reg_t        wb_q;
    logic               retired_q;
    logic               order_en;
    logic               wr_ok;
    logic [ORDER_W-1:0] order_q;

    // A flush squashes the committing instruction, so it must not consume an order number.
    assign order_en = wb.increment & ~wb.stall & ~wb.flush;

    order_counter u_order (
        .clk   (clk),
        .rst   (rst),
        .en    (order_en),
        .order (order_q)
    );

    // Pipeline register: stall holds, flush loads a bubble, reset wins over both.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q <= WB_BUBBLE;
        end else if (!wb.stall) begin
            wb_q <= wb.flush ? WB_BUBBLE : wb.mem_wb_reg;
        end
    end

    // Retired flag: set once a held committing entry has been presented for a cycle,
    // cleared whenever a new entry loads, so monitor/write fire once per entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= 1'b0;
        end else if (!wb.stall) begin
            retired_q <= 1'b0;
        end else if (wb_q.commit) begin
            retired_q <= 1'b1;
        end
    end

    // Output decode: write/forward qualification and monitor fields from the held entry.
    always_comb begin
        wr_ok            = wb_q.commit & wb_q.regf_we & (wb_q.rd_s != '0);

        wb.order         = order_q;

        wb.regf_we       = wr_ok & ~retired_q;
        wb.rd_s          = wb_q.rd_s;
        wb.rd_v          = wb_q.rd_v;

        wb.fwd_valid     = wr_ok;
        wb.fwd_rd_s      = wb_q.rd_s;
        wb.fwd_rd_v      = wb_q.rd_v;

        wb.mon_valid     = wb_q.commit & ~retired_q;
        wb.mon_order     = wb_q.order;
        wb.mon_inst      = wb_q.inst;
        wb.mon_pc_rdata  = wb_q.pc;
        wb.mon_pc_wdata  = wb_q.pc_next;
        wb.mon_rs1_addr  = wb_q.rs1_s;
        wb.mon_rs2_addr  = wb_q.rs2_s;
        wb.mon_rs1_rdata = wb_q.rs1_v;
        wb.mon_rs2_rdata = wb_q.rs2_v;
        wb.mon_rd_addr   = wr_ok ? wb_q.rd_s : '0;
        wb.mon_rd_wdata  = wr_ok ? wb_q.rd_v : '0;
    end

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: directed stimulus pushes expected retirements into a
// scoreboard queue; a negedge monitor pops and compares on every mon_valid.
module tb_wb_stage;
    import rv32i_types::*;

    typedef struct {
        logic [63:0] order;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [4:0]  rs1_s;
        logic [4:0]  rs2_s;
        logic [31:0] rs1_v;
        logic [31:0] rs2_v;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic        we;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mon_en = 1'b0;
    logic [63:0] model_order;
    exp_t        exp_q[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          n_mon = 0;
    int          n_push = 0;

    always #5 clk = ~clk;

    wb_stage_if bus ();

    wb_stage dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    function automatic mem_wb_reg_t mk(logic [63:0] ord, logic we, logic [4:0] rd, logic [31:0] rdv);
        mem_wb_reg_t e;
        e         = '0;
        e.commit  = 1'b1;
        e.order   = ord;
        e.inst    = {12'h001, 5'd3, 3'b000, rd, 7'h13};
        e.pc      = 32'h0000_1000 + {ord[29:0], 2'b00};
        e.pc_next = e.pc + 32'd4;
        e.rs1_s   = 5'd3;
        e.rs2_s   = 5'd4;
        e.rs1_v   = 32'h1111_0000 ^ rdv;
        e.rs2_v   = 32'h2222_0000 + rdv;
        e.regf_we = we;
        e.rd_s    = rd;
        e.rd_v    = rdv;
        return e;
    endfunction

    // Drive one cycle of inputs, record the expected retirement, advance the model order.
    task automatic cycle(mem_wb_reg_t e, logic incr, logic stl, logic fl);
        exp_t x;
        bus.mem_wb_reg = e;
        bus.increment  = incr;
        bus.stall      = stl;
        bus.flush      = fl;
        if (!rst && !stl && !fl && e.commit) begin
            x.order    = e.order;
            x.inst     = e.inst;
            x.pc       = e.pc;
            x.pc_next  = e.pc_next;
            x.rs1_s    = e.rs1_s;
            x.rs2_s    = e.rs2_s;
            x.rs1_v    = e.rs1_v;
            x.rs2_v    = e.rs2_v;
            x.we       = e.regf_we && (e.rd_s != 5'd0);
            x.rd_addr  = x.we ? e.rd_s : 5'd0;
            x.rd_wdata = x.we ? e.rd_v : 32'd0;
            exp_q.push_back(x);
            n_push++;
        end
        if (!rst && incr && !stl && !fl) model_order = model_order + 64'd1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every retirement against the scoreboard head.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("regf_we_without_mon_valid", {63'd0, bus.regf_we & ~bus.mon_valid}, 64'd0);
            if (bus.mon_valid === 1'b1) begin
                n_mon++;
                if (exp_q.size() == 0) begin
                    chk("mon_valid_unexpected", {63'd0, bus.mon_valid}, 64'd0);
                end else begin
                    exp_t x;
                    x = exp_q.pop_front();
                    chk("mon_order",     bus.mon_order,                x.order);
                    chk("mon_inst",      {32'd0, bus.mon_inst},        {32'd0, x.inst});
                    chk("mon_pc_rdata",  {32'd0, bus.mon_pc_rdata},    {32'd0, x.pc});
                    chk("mon_pc_wdata",  {32'd0, bus.mon_pc_wdata},    {32'd0, x.pc_next});
                    chk("mon_rs1_addr",  {59'd0, bus.mon_rs1_addr},    {59'd0, x.rs1_s});
                    chk("mon_rs2_addr",  {59'd0, bus.mon_rs2_addr},    {59'd0, x.rs2_s});
                    chk("mon_rs1_rdata", {32'd0, bus.mon_rs1_rdata},   {32'd0, x.rs1_v});
                    chk("mon_rs2_rdata", {32'd0, bus.mon_rs2_rdata},   {32'd0, x.rs2_v});
                    chk("mon_rd_addr",   {59'd0, bus.mon_rd_addr},     {59'd0, x.rd_addr});
                    chk("mon_rd_wdata",  {32'd0, bus.mon_rd_wdata},    {32'd0, x.rd_wdata});
                    chk("mon_regf_we",   {63'd0, bus.regf_we},         {63'd0, x.we});
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        rst            = 1'b1;
        model_order    = 64'd0;
        bus.mem_wb_reg = mk(64'h77, 1'b1, 5'd9, 32'h1234);
        bus.increment  = 1'b1;
        bus.stall      = 1'b1;
        bus.flush      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst            = 1'b0;
        bus.mem_wb_reg = WB_BUBBLE;
        bus.increment  = 1'b0;
        bus.stall      = 1'b0;
        bus.flush      = 1'b0;
        mon_en         = 1'b1;
        chk("reset_order",     bus.order,                 64'd0);
        chk("reset_mon_valid", {63'd0, bus.mon_valid},    64'd0);
        chk("reset_regf_we",   {63'd0, bus.regf_we},      64'd0);
        chk("reset_fwd_valid", {63'd0, bus.fwd_valid},    64'd0);

        // Three back-to-back commits to x1/x2/x3.
        cycle(mk(model_order, 1'b1, 5'd1, 32'h11), 1'b1, 1'b0, 1'b0);
        cycle(mk(model_order, 1'b1, 5'd2, 32'h22), 1'b1, 1'b0, 1'b0);
        cycle(mk(model_order, 1'b1, 5'd3, 32'h33), 1'b1, 1'b0, 1'b0);
        chk("order_after_three", bus.order, 64'd3);

        // addi x5 = 0x2A held by a four-cycle stall.
        cycle(mk(model_order, 1'b1, 5'd5, 32'h2A), 1'b1, 1'b0, 1'b0);
        chk("stall_first_regf_we",  {63'd0, bus.regf_we},   64'd1);
        chk("stall_first_fwd_v",    {63'd0, bus.fwd_valid}, 64'd1);
        chk("stall_first_fwd_rd_v", {32'd0, bus.fwd_rd_v},  64'h2A);
        chk("stall_first_fwd_rd_s", {59'd0, bus.fwd_rd_s},  64'd5);
        for (int i = 0; i < 4; i++) begin
            cycle(mk(64'h99, 1'b1, 5'd7, 32'hBAD), 1'b1, 1'b1, 1'b0);
            chk("stall_hold_fwd_v",    {63'd0, bus.fwd_valid}, 64'd1);
            chk("stall_hold_fwd_rd_v", {32'd0, bus.fwd_rd_v},  64'h2A);
            chk("stall_hold_regf_we",  {63'd0, bus.regf_we},   64'd0);
            chk("stall_hold_mon",      {63'd0, bus.mon_valid}, 64'd0);
            chk("stall_hold_order",    bus.order,              64'd4);
        end
        cycle(WB_BUBBLE, 1'b0, 1'b0, 1'b0);
        chk("bubble_fwd_valid", {63'd0, bus.fwd_valid}, 64'd0);

        // increment together with flush: squashed, order unchanged.
        cycle(mk(model_order, 1'b1, 5'd6, 32'h66), 1'b1, 1'b0, 1'b1);
        chk("flush_order",     bus.order,              64'd4);
        chk("flush_mon_valid", {63'd0, bus.mon_valid}, 64'd0);
        cycle(mk(model_order, 1'b1, 5'd6, 32'h66), 1'b1, 1'b0, 1'b0);
        chk("after_flush_order", bus.order, 64'd5);

        // Commit targeting x0.
        cycle(mk(model_order, 1'b1, 5'd0, 32'hDEAD), 1'b1, 1'b0, 1'b0);
        chk("x0_regf_we",      {63'd0, bus.regf_we},      64'd0);
        chk("x0_fwd_valid",    {63'd0, bus.fwd_valid},    64'd0);
        chk("x0_mon_valid",    {63'd0, bus.mon_valid},    64'd1);
        chk("x0_mon_rd_addr",  {59'd0, bus.mon_rd_addr},  64'd0);
        chk("x0_mon_rd_wdata", {32'd0, bus.mon_rd_wdata}, 64'd0);
        cycle(WB_BUBBLE, 1'b0, 1'b0, 1'b0);

        // Order counter wrap from all-ones.
        force dut.u_order.order_q = '1;
        #1;
        release dut.u_order.order_q;
        model_order = '1;
        chk("preload_order", bus.order, 64'hFFFF_FFFF_FFFF_FFFF);
        cycle(mk(model_order, 1'b1, 5'd9, 32'h99), 1'b1, 1'b0, 1'b0);
        chk("wrap_order", bus.order, 64'd0);

        // Reset while stalled on a committing entry.
        cycle(mk(model_order, 1'b1, 5'd10, 32'hA0), 1'b1, 1'b0, 1'b0);
        chk("pre_reset_order", bus.order, 64'd1);
        cycle(mk(64'h55, 1'b1, 5'd11, 32'hB0), 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        cycle(mk(64'h55, 1'b1, 5'd11, 32'hB0), 1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        model_order = 64'd0;
        chk("rst_stall_mon_valid", {63'd0, bus.mon_valid}, 64'd0);
        chk("rst_stall_regf_we",   {63'd0, bus.regf_we},   64'd0);
        chk("rst_stall_fwd_valid", {63'd0, bus.fwd_valid}, 64'd0);
        chk("rst_stall_order",     bus.order,              64'd0);
        cycle(WB_BUBBLE, 1'b0, 1'b0, 1'b0);
        cycle(WB_BUBBLE, 1'b0, 1'b0, 1'b0);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("retire_count",     64'(n_mon),        64'(n_push));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameters: none; all widths come from rv32i_types.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 mem_wb_reg  input  mem_wb_reg_t  entry produced by the memory stage this cycle.
REQ-005 stall  input  1  hold: pipeline register, order counter and retire flag keep their value.
REQ-006 flush  input  1  squash: the incoming entry is loaded as a bubble.
REQ-007 increment  input  1  memory stage presents a committing instruction.
REQ-008 order  output  64  current commit order number, fed back to the memory stage.
REQ-009 regf_we  output  1  register-file write enable.
REQ-010 rd_s  output  5  register-file write address.
REQ-011 rd_v  output  32  register-file write data.
REQ-012 fwd_valid  output  1  WB forwarding source valid.
REQ-013 fwd_rd_s  output  5  forwarding destination register.
REQ-014 fwd_rd_v  output  32  forwarding data.
REQ-015 mon_valid, mon_order(64), mon_inst(32), mon_pc_rdata(32), mon_pc_wdata(32)  outputs  retirement monitor.
REQ-016 mon_rs1_addr(5), mon_rs2_addr(5), mon_rs1_rdata(32), mon_rs2_rdata(32), mon_rd_addr(5), mon_rd_wdata(32)  outputs  monitor operands.

Function
REQ-017 wb_q (mem_wb_reg_t) SHALL load on each edge with stall=0: mem_wb_reg if flush=0, all-zero bubble (commit=0) if flush=1.
REQ-018 Latency: entry on mem_wb_reg at edge N (stall=0, flush=0) SHALL drive outputs from N+1 onward.
REQ-019 stall=1 SHALL take priority over flush; flush is honoured only in a cycle with stall=0.
REQ-020 order_q (64 bit) SHALL increment by 1 at an edge with increment=1, stall=0, flush=0; otherwise it holds.
REQ-021 order_q SHALL wrap from 2^64-1 to 0; order output = order_q combinationally.
REQ-022 retired_q SHALL clear when a new entry loads and set at the first edge after a committing entry is presented.
REQ-023 mon_valid = wb_q.commit & ~retired_q; it fires exactly once per committed entry, including under multi-cycle stall.
REQ-024 regf_we = wb_q.commit & wb_q.regf_we & (wb_q.rd_s != 0) & ~retired_q.
REQ-025 rd_s and rd_v SHALL equal the wb_q fields.
REQ-026 fwd_valid = wb_q.commit & wb_q.regf_we & (wb_q.rd_s != 0), independent of retired_q (held entries keep forwarding).
REQ-027 mon_rd_addr = rd_s when regf_we is effective, else 0; mon_rd_wdata is 0 when mon_rd_addr = 0.
REQ-028 mon_order/inst/pc_rdata/pc_wdata/rs*_addr/rs*_rdata SHALL equal the wb_q fields order/inst/pc/pc_next/rs*_s/rs*_v.
REQ-029 Simultaneous increment and flush SHALL neither load the entry nor advance order_q.

Reset
REQ-030 With rst=1 at an edge: wb_q=0, order_q=0, retired_q=0; this overrides stall and flush.
REQ-031 Reset mid-stall SHALL drop the held entry with no mon_valid or regf_we pulse in the following cycle.
REQ-032 In the cycle after reset, all outputs are 0 (order=0, mon_valid=0, regf_we=0, fwd_valid=0).

Structure
REQ-033 mem_wb_reg_t stays in rv32i_types; add ORDER_W=64 there, and the zero-bubble constant in the same package.
REQ-034 The order counter is one natural sub-module, order_counter (clk, rst, en, order).

Verification
REQ-035 Reset, then three back-to-back commits to x1/x2/x3 -> mon_valid 3 cycles, mon_order 0,1,2, order=3.
REQ-036 Commit addi x5 (rd_v=0x2A) with stall=1 for 4 cycles -> mon_valid and regf_we one cycle only; fwd_valid=1 and fwd_rd_v=0x2A all 5 cycles.
REQ-037 increment=1 with flush=1 -> next cycle mon_valid=0, order unchanged; next commit uses the same order value.
REQ-038 Commit with rd_s=0, rd_v=0xDEAD -> regf_we=0, fwd_valid=0, mon_rd_addr=0, mon_rd_wdata=0, mon_valid=1.
REQ-039 Preload order_q=2^64-1, commit once -> mon_order=0xFFFF_FFFF_FFFF_FFFF, then order=0.
REQ-040 rst=1 while stalled on a committing entry -> next cycle mon_valid=0, order=0.
